vec_vsetvl_unit: RTL

// Executes vsetvli / vsetivli / vsetvl handed over by the scalar core: decodes the new vtype,

---
 rtl/vec_vsetvl_unit_pkg.sv | 55 +++++
 rtl/vec_vlmax_calc.sv | 34 +++
 rtl/vec_vsetvl_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vec_vsetvl_unit_pkg.sv
// rtl/vec_vsetvl_unit_pkg.sv - vset* decode constants, vtype field layout and unit state types
package vec_vsetvl_unit_pkg;

  localparam logic [6:0] VSET_OPCODE = 7'h57;
  localparam logic [2:0] VSET_FUNCT3 = 3'b111;

  localparam int VTYPE_VLMUL_LSB = 0;
  localparam int VTYPE_VSEW_LSB  = 3;
  localparam int VTYPE_RSVD_LSB  = 8;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } vlmul_e;

  typedef enum logic [2:0] {
    EW_8  = 3'd0,
    EW_16 = 3'd1,
    EW_32 = 3'd2,
    EW_64 = 3'd3
  } vew_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_COMMIT,
    ST_RESP
  } vsetvl_state_e;

  typedef enum logic [1:0] {
    VSET_NONE,
    VSET_VLI,
    VSET_IVLI,
    VSET_VL
  } vset_kind_e;

  function automatic vset_kind_e vset_decode(input logic [31:0] inst);
    vset_decode = VSET_NONE;
    if (inst[6:0] == VSET_OPCODE && inst[14:12] == VSET_FUNCT3) begin
      if (!inst[31])
        vset_decode = VSET_VLI;
      else if (inst[30])
        vset_decode = VSET_IVLI;
      else if (inst[29:25] == 5'b00000)
        vset_decode = VSET_VL;
    end
  endfunction

endpackage

// File: rtl/vec_vlmax_calc.sv
// rtl/vec_vlmax_calc.sv - vtype legality, VLMAX and granted vl, purely combinational
module vec_vlmax_calc
  import vec_vsetvl_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512
) (
  input  logic [2:0]      vsew_i,
  input  logic [2:0]      vlmul_i,
  input  logic            rsvd_i,
  input  logic [XLEN-1:0] avl_i,
  output logic            vill_o,
  output logic [XLEN-1:0] vl_o
);

  localparam logic [XLEN-1:0] VLEN_X = XLEN'(VLEN);

  logic [2:0]      shamt;
  logic [XLEN-1:0] vlmax;

  // VLEN/SEW via right shift by log2(SEW); LMUL is a left shift since only integer LMUL is legal
  always_comb begin
    vill_o = rsvd_i || (vsew_i > EW_64) || (vlmul_i >= LMUL_RSVD);
    shamt  = 3'd3 + {1'b0, vsew_i[1:0]};
    vlmax  = (VLEN_X >> shamt) << vlmul_i[1:0];
    if (vill_o)
      vl_o = '0;
    else if (avl_i <= vlmax)
      vl_o = avl_i;
    else
      vl_o = vlmax;
  end

endmodule

// File: rtl/vec_vsetvl_unit.sv
// rtl/vec_vsetvl_unit.sv - vsetvli/vsetivli/vsetvl execution, CSR commit and rd response
module vec_vsetvl_unit
  import vec_vsetvl_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [XLEN-1:0] cur_vl_i,
  output logic [XLEN-1:0] vtype_o,
  output logic [XLEN-1:0] vl_o,
  output logic            csrwr_en_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_valid_o,
  input  logic            rd_ready_i,
  output logic            illegal_o
);

  localparam logic [XLEN-1:0] VTYPE_ILL = {1'b1, {(XLEN-1){1'b0}}};

  vsetvl_state_e   state_q, state_d;
  logic            inst_ready_q, inst_ready_d;
  logic            csrwr_en_q, csrwr_en_d;
  logic            rd_valid_q, rd_valid_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] vtype_q, vtype_d;
  logic [XLEN-1:0] vl_q, vl_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] vtype_raw_q, vtype_raw_d;
  logic [XLEN-1:0] avl_q, avl_d;
  logic [4:0]      rd_q, rd_d;
  logic            rs1_zero_q, rs1_zero_d;

  vset_kind_e      kind;
  logic [XLEN-1:0] avl_sel;
  logic            vill_calc;
  logic [XLEN-1:0] vl_calc;

  assign kind = vset_decode(inst_i[31:0]);

  // rs1=x0 with rd!=x0 requests VLMAX; with rd=x0 it keeps the current vl where still legal
  assign avl_sel = !rs1_zero_q      ? avl_q :
                   (rd_q != 5'd0)   ? {XLEN{1'b1}} : cur_vl_i;

  vec_vlmax_calc #(
    .XLEN (XLEN),
    .VLEN (VLEN)
  ) u_vlmax_calc (
    .vsew_i  (vtype_raw_q[VTYPE_VSEW_LSB +: 3]),
    .vlmul_i (vtype_raw_q[VTYPE_VLMUL_LSB +: 3]),
    .rsvd_i  (|vtype_raw_q[XLEN-1:VTYPE_RSVD_LSB]),
    .avl_i   (avl_sel),
    .vill_o  (vill_calc),
    .vl_o    (vl_calc)
  );

  always_comb begin
    state_d      = state_q;
    inst_ready_d = inst_ready_q;
    csrwr_en_d   = 1'b0;
    rd_valid_d   = rd_valid_q;
    illegal_d    = 1'b0;
    vtype_d      = vtype_q;
    vl_d         = vl_q;
    rd_data_d    = rd_data_q;
    rd_addr_d    = rd_addr_q;
    vtype_raw_d  = vtype_raw_q;
    avl_d        = avl_q;
    rd_d         = rd_q;
    rs1_zero_d   = rs1_zero_q;

    case (state_q)
      ST_IDLE: begin
        inst_ready_d = 1'b1;
        if (inst_valid_i) begin
          if (kind == VSET_NONE) begin
            illegal_d = 1'b1;
          end else begin
            state_d      = ST_CALC;
            inst_ready_d = 1'b0;
            rd_d         = inst_i[11:7];
            avl_d        = rs1_i;
            rs1_zero_d   = (inst_i[19:15] == 5'd0);
            case (kind)
              VSET_IVLI: begin
                vtype_raw_d = XLEN'(inst_i[29:20]);
                avl_d       = XLEN'(inst_i[19:15]);
                rs1_zero_d  = 1'b0;
              end
              VSET_VL:  vtype_raw_d = rs2_i;
              default:  vtype_raw_d = XLEN'(inst_i[30:20]);
            endcase
          end
        end
      end
      ST_CALC: begin
        vtype_d    = vill_calc ? VTYPE_ILL : {{(XLEN-8){1'b0}}, vtype_raw_q[7:0]};
        vl_d       = vl_calc;
        csrwr_en_d = 1'b1;
        state_d    = ST_COMMIT;
      end
      ST_COMMIT: begin
        rd_valid_d = 1'b1;
        rd_data_d  = vl_q;
        rd_addr_d  = rd_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rd_ready_i) begin
          rd_valid_d   = 1'b0;
          inst_ready_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        inst_ready_d = 1'b1;
        rd_valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      inst_ready_q <= 1'b1;
      csrwr_en_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      illegal_q    <= 1'b0;
      vtype_q      <= VTYPE_ILL;
      vl_q         <= '0;
      rd_data_q    <= '0;
      rd_addr_q    <= '0;
      vtype_raw_q  <= '0;
      avl_q        <= '0;
      rd_q         <= '0;
      rs1_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_ready_q <= inst_ready_d;
      csrwr_en_q   <= csrwr_en_d;
      rd_valid_q   <= rd_valid_d;
      illegal_q    <= illegal_d;
      vtype_q      <= vtype_d;
      vl_q         <= vl_d;
      rd_data_q    <= rd_data_d;
      rd_addr_q    <= rd_addr_d;
      vtype_raw_q  <= vtype_raw_d;
      avl_q        <= avl_d;
      rd_q         <= rd_d;
      rs1_zero_q   <= rs1_zero_d;
    end
  end

  assign inst_ready_o = inst_ready_q;
  assign csrwr_en_o   = csrwr_en_q;
  assign rd_valid_o   = rd_valid_q;
  assign illegal_o    = illegal_q;
  assign vtype_o      = vtype_q;
  assign vl_o         = vl_q;
  assign rd_data_o    = rd_data_q;
  assign rd_addr_o    = rd_addr_q;

endmodule
